// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache controller slice.
//   - state_t        : controller FSM states
//   - LINE_W/WORD_W  : SRAM line width and pipeline word width
//   - OFFSET_SEL_BIT : address bit choosing the word within a line
//   - LINE_ALIGN_W   : number of low address bits cleared to align to a line
package cache_controller_pkg;

    localparam int LINE_W         = 64;
    localparam int WORD_W         = 32;
    localparam int OFFSET_SEL_BIT = 2;
    localparam int LINE_ALIGN_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cache_controller_stats.sv
// cache_stats: hit / miss event counters for the cache controller.
// Only instantiated when CACHE_STATS_EN is defined.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (clears both counters)
//   hit_evt       : one-cycle pulse per read hit
//   miss_evt      : one-cycle pulse per read miss
//   hit_count     : number of hits, wraps modulo 2^32
//   miss_count    : number of misses, wraps modulo 2^32
module cache_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_evt,
    input  logic        miss_evt,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    logic [1:0]  evt;
    logic [31:0] cnt_reg [2];

    assign evt = {miss_evt, hit_evt};

    // Index 0 counts hits, index 1 counts misses.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg[gi] <= '0;
                end else if (evt[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign hit_count  = cnt_reg[0];
    assign miss_count = cnt_reg[1];

endmodule

// File: rtl/cache_controller.sv
// cache_controller: sequences MEM-stage loads/stores into cache lookups,
// SRAM line fills and write-through SRAM word writes (no write-allocate).
// Optional feature macro: CACHE_STATS_EN (adds hit_count / miss_count).
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   MEM_R_EN, MEM_W_EN            : MEM-stage load / store request (store wins)
//   address, write_data           : request address and store data
//   read_data, ready              : load result, pipeline run (0 = freeze)
//   cache_hit, cache_read_data    : cache lookup result for address
//   cache_fill, cache_invalidate  : one-cycle strobes to the cache
//   SRAM_R_EN, SRAM_W_EN          : SRAM line read / word write requests
//   SRAM_address, SRAM_write_data : SRAM address and store data
//   SRAM_ready, SRAM_read_data    : SRAM completion pulse and fill line
//   hit_count, miss_count         : statistics (CACHE_STATS_EN only)
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int LINE_W = cache_controller_pkg::LINE_W,
    parameter int WORD_W = cache_controller_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              ready,
    input  logic              cache_hit,
    input  logic [WORD_W-1:0] cache_read_data,
    output logic              cache_fill,
    output logic              cache_invalidate,
    output logic              SRAM_R_EN,
    output logic              SRAM_W_EN,
    output logic [31:0]       SRAM_address,
    output logic [WORD_W-1:0] SRAM_write_data,
    input  logic              SRAM_ready,
    input  logic [LINE_W-1:0] SRAM_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    state_t            state_reg, state_next;
    logic [31:0]       addr_reg, addr_next;
    logic [WORD_W-1:0] wdata_reg, wdata_next;
    logic [WORD_W-1:0] word_reg, word_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            word_reg  <= word_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        word_next        = word_reg;
        ready            = 1'b0;
        read_data        = word_reg;
        cache_fill       = 1'b0;
        cache_invalidate = 1'b0;
        SRAM_R_EN        = 1'b0;
        SRAM_W_EN        = 1'b0;
        SRAM_address     = '0;
        SRAM_write_data  = '0;

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (MEM_W_EN) begin
                    // Stores go straight to SRAM; a hitting way is dropped
                    // rather than updated, keeping the cache path read-only.
                    cache_invalidate = cache_hit;
                    addr_next        = address;
                    wdata_next       = write_data;
                    state_next       = WR;
                    ready            = 1'b0;
                end else if (MEM_R_EN) begin
                    if (cache_hit) begin
                        read_data = cache_read_data;
                    end else begin
                        ready      = 1'b0;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                // The pipeline holds address stable while frozen, so the
                // live address is used here instead of a latched copy.
                SRAM_R_EN    = 1'b1;
                SRAM_address = {address[31:LINE_ALIGN_W], {LINE_ALIGN_W{1'b0}}};
                if (SRAM_ready) begin
                    cache_fill = 1'b1;
                    // Offset bit set selects the low half of the line.
                    word_next  = address[OFFSET_SEL_BIT] ? SRAM_read_data[WORD_W-1:0]
                                                         : SRAM_read_data[LINE_W-1 -: WORD_W];
                    state_next = DONE;
                end
            end
            WR: begin
                SRAM_W_EN       = 1'b1;
                SRAM_address    = addr_reg;
                SRAM_write_data = wdata_reg;
                if (SRAM_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic hit_evt;
    logic miss_evt;

    assign hit_evt  = (state_reg == IDLE) && MEM_R_EN && !MEM_W_EN &&  cache_hit;
    assign miss_evt = (state_reg == IDLE) && MEM_R_EN && !MEM_W_EN && !cache_hit;

    cache_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .hit_evt    (hit_evt),
        .miss_evt   (miss_evt),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller. Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge.
// Stats checks are active when CACHE_STATS_EN is defined.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic        cache_hit;
    logic [31:0] cache_read_data;
    logic        cache_fill, cache_invalidate;
    logic        SRAM_R_EN, SRAM_W_EN;
    logic [31:0] SRAM_address, SRAM_write_data;
    logic        SRAM_ready;
    logic [63:0] SRAM_read_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_R_EN         (MEM_R_EN),
        .MEM_W_EN         (MEM_W_EN),
        .address          (address),
        .write_data       (write_data),
        .read_data        (read_data),
        .ready            (ready),
        .cache_hit        (cache_hit),
        .cache_read_data  (cache_read_data),
        .cache_fill       (cache_fill),
        .cache_invalidate (cache_invalidate),
        .SRAM_R_EN        (SRAM_R_EN),
        .SRAM_W_EN        (SRAM_W_EN),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_ready       (SRAM_ready),
        .SRAM_read_data   (SRAM_read_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        cache_hit  = 1'b0;
        SRAM_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Read miss with SRAM_ready on the n-th RD_MISS cycle; only checks ready.
    task automatic quick_miss(input logic [31:0] a, input int n);
        MEM_R_EN = 1'b1; cache_hit = 1'b0; address = a;
        tick();
        for (int k = 1; k <= n; k++) begin
            SRAM_ready = (k == n);
            tick();
        end
        SRAM_ready = 1'b0;
        @(negedge clk);
        check_val("quick_miss_done_ready", ready, 1);
        tick();
        idle_inputs();
    endtask

    initial begin
        int stall;
        idle_inputs();
        address         = 32'h0;
        write_data      = 32'h0;
        cache_read_data = 32'h0;
        SRAM_read_data  = 64'h0;
        rst             = 1'b1;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_read_data", read_data, 0);
        check_val("rst_sram_r", SRAM_R_EN, 0);
        check_val("rst_sram_w", SRAM_W_EN, 0);
        check_val("rst_fill", cache_fill, 0);
        check_val("rst_inval", cache_invalidate, 0);
`ifdef CACHE_STATS_EN
        check_val("rst_hits", hit_count, 0);
        check_val("rst_misses", miss_count, 0);
`endif
        $display("txn reset: ready=%0b read_data=0x%0h", ready, read_data);
        tick();

        // Read hit
        MEM_R_EN = 1'b1; cache_hit = 1'b1; cache_read_data = 32'hDEADBEEF; address = 32'h100;
        @(negedge clk);
        check_val("hit_ready", ready, 1);
        check_val("hit_data", read_data, 32'hDEADBEEF);
        check_val("hit_sram_r", SRAM_R_EN, 0);
        $display("txn read_hit: addr=0x%0h data=0x%0h", address, read_data);
        tick();
        idle_inputs();

        // Read miss: 5 RD_MISS cycles, SRAM_ready on the 5th
        stall = 0;
        MEM_R_EN = 1'b1; cache_hit = 1'b0; address = 32'h0000040C;
        SRAM_read_data = 64'h11112222_33334444;
        @(negedge clk);
        check_val("miss_req_ready", ready, 0);
        if (!ready) stall++;
        tick();
        for (int k = 1; k <= 5; k++) begin
            SRAM_ready = (k == 5);
            @(negedge clk);
            check_val("miss_sram_r", SRAM_R_EN, 1);
            check_val("miss_sram_w", SRAM_W_EN, 0);
            check_val("miss_sram_addr", SRAM_address, 32'h00000408);
            check_val("miss_fill", cache_fill, (k == 5));
            if (!ready) stall++;
            tick();
        end
        SRAM_ready = 1'b0;
        @(negedge clk);
        check_val("miss_done_ready", ready, 1);
        check_val("miss_done_data", read_data, 32'h33334444);
        check_val("miss_done_fill", cache_fill, 0);
        check_val("miss_done_sram_r", SRAM_R_EN, 0);
        check_val("miss_stall", stall, 6);
        $display("txn read_miss: addr=0x%0h data=0x%0h stall=%0d", address, read_data, stall);
        tick();
        idle_inputs();

        // Store hit: invalidate only in the request cycle
        MEM_W_EN = 1'b1; cache_hit = 1'b1; address = 32'h410; write_data = 32'hCAFE0001;
        @(negedge clk);
        check_val("st_req_inval", cache_invalidate, 1);
        check_val("st_req_ready", ready, 0);
        tick();
        cache_hit = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            SRAM_ready = (k == 3);
            @(negedge clk);
            check_val("st_inval", cache_invalidate, 0);
            check_val("st_sram_w", SRAM_W_EN, 1);
            check_val("st_sram_r", SRAM_R_EN, 0);
            check_val("st_sram_addr", SRAM_address, 32'h410);
            check_val("st_sram_data", SRAM_write_data, 32'hCAFE0001);
            check_val("st_ready", ready, 0);
            tick();
        end
        SRAM_ready = 1'b0;
        @(negedge clk);
        check_val("st_done_ready", ready, 1);
        check_val("st_done_sram_w", SRAM_W_EN, 0);
        $display("txn store_hit: addr=0x410 data=0xcafe0001");
        tick();
        idle_inputs();

        // Simultaneous read and write: write path
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; cache_hit = 1'b0;
        address = 32'h500; write_data = 32'h0BADF00D;
        @(negedge clk);
        check_val("rw_req_ready", ready, 0);
        check_val("rw_req_inval", cache_invalidate, 0);
        tick();
        for (int k = 1; k <= 2; k++) begin
            SRAM_ready = (k == 2);
            @(negedge clk);
            check_val("rw_sram_r", SRAM_R_EN, 0);
            check_val("rw_sram_w", SRAM_W_EN, 1);
            check_val("rw_sram_data", SRAM_write_data, 32'h0BADF00D);
            tick();
        end
        SRAM_ready = 1'b0;
        @(negedge clk);
        check_val("rw_done_ready", ready, 1);
        check_val("rw_done_sram_r", SRAM_R_EN, 0);
        $display("txn read_write: addr=0x500 data=0xbadf00d");
        tick();
        idle_inputs();

        // Reset in the middle of a miss
        MEM_R_EN = 1'b1; cache_hit = 1'b0; address = 32'h604;
        tick();
        tick();
        @(negedge clk);
        check_val("rm_pre_sram_r", SRAM_R_EN, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("rm_ready", ready, 1);
        check_val("rm_sram_r", SRAM_R_EN, 0);
        check_val("rm_fill", cache_fill, 0);
        check_val("rm_read_data", read_data, 0);
        tick();
        SRAM_ready = 1'b1;
        SRAM_read_data = 64'hAAAABBBB_CCCCDDDD;
        @(negedge clk);
        check_val("rm_stray_fill", cache_fill, 0);
        check_val("rm_stray_ready", ready, 1);
        $display("txn reset_mid_miss: ready=%0b read_data=0x%0h", ready, read_data);
        tick();
        SRAM_ready = 1'b0;
        @(negedge clk);
        check_val("rm_after_stray_data", read_data, 0);
        check_val("rm_after_stray_sram_r", SRAM_R_EN, 0);
        tick();

`ifdef CACHE_STATS_EN
        // 3 hits + 2 misses since the last reset
        for (int i = 0; i < 3; i++) begin
            MEM_R_EN = 1'b1; cache_hit = 1'b1; cache_read_data = 32'h1000 + i;
            tick();
        end
        idle_inputs();
        quick_miss(32'h700, 2);
        quick_miss(32'h708, 1);
        @(negedge clk);
        check_val("stats_hits", hit_count, 3);
        check_val("stats_misses", miss_count, 2);
        $display("txn stats: hits=%0d misses=%0d", hit_count, miss_count);
        tick();
        do_reset();
        @(negedge clk);
        check_val("stats_rst_hits", hit_count, 0);
        check_val("stats_rst_misses", miss_count, 0);
        $display("txn stats_reset: hits=%0d misses=%0d", hit_count, miss_count);
        tick();
`else
        quick_miss(32'h700, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller between the MEM stage, the 2-way data cache and the SRAM controller. It turns MEM-stage read/write requests into cache lookups, SRAM line fills and write-through SRAM writes, and freezes the pipeline while SRAM is busy. Policy is write-through, no write-allocate. Lines are 64 bits, words are 32 bits.

## Interface
- Parameters:
- `LINE_W`, 64, SRAM line width in bits.
- `WORD_W`, 32, pipeline data width in bits.
- Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset. This is already decided.
- `MEM_R_EN` input 1: MEM-stage load request.
- `MEM_W_EN` input 1: MEM-stage store request.
- `address` input 32: request address. Held stable while `ready`=0.
- `write_data` input 32: store data.
- `read_data` output 32: load result, valid when `ready`=1 and the request is a load.
- `ready` output 1: 0 freezes the pipeline.
- `cache_hit` input 1: cache hit flag for `address`.
- `cache_read_data` input 32: cache word for `address`.
- `cache_fill` output 1: one-cycle strobe telling the cache to write `SRAM_read_data`.
- `cache_invalidate` output 1: one-cycle strobe that invalidates the hitting way on a store.
- `SRAM_R_EN` output 1: SRAM line read request.
- `SRAM_W_EN` output 1: SRAM word write request.
- `SRAM_address` output 32: SRAM address.
- `SRAM_write_data` output 32: SRAM store data.
- `SRAM_ready` input 1: one-cycle completion pulse from the SRAM controller.
- `SRAM_read_data` input 64: fill line, routed to the cache as well.

## Operation
- FSM states: IDLE, RD_MISS, WR, DONE. Reset state is IDLE.
- IDLE:
  - No request: `ready`=1 (combinational).
  - `MEM_W_EN`=1: `cache_invalidate`=`cache_hit` this cycle, latch `address`/`write_data`, go to WR, `ready`=0.
  - `MEM_R_EN`=1, `cache_hit`=1: `read_data`=`cache_read_data`, `ready`=1, stay in IDLE.
  - `MEM_R_EN`=1, `cache_hit`=0: go to RD_MISS, `ready`=0.
- Simultaneous `MEM_R_EN` and `MEM_W_EN`: the write wins.
- RD_MISS:
  - `SRAM_R_EN`=1, `SRAM_address`={`address`[31:3],3'b000}.
  - On `SRAM_ready`=1: `cache_fill`=1 in that same cycle, latch word (`address`[2] ? `SRAM_read_data`[31:0] : `SRAM_read_data`[63:32]), go to DONE.
- WR:
  - `SRAM_W_EN`=1, `SRAM_address`=latched address, `SRAM_write_data`=latched data.
  - On `SRAM_ready`=1: go to DONE.
- DONE: `ready`=1 for exactly one cycle; `read_data`=latched word (undefined for stores), then go to IDLE.
- `SRAM_R_EN`/`SRAM_W_EN` are decoded from the registered state only. They are never both 1 and stay held until `SRAM_ready`.
- `SRAM_ready` outside RD_MISS/WR is ignored.

## Timing
- Read hit: 0 extra cycles; `ready`=1 in the request cycle.
- Read miss: request cycle, then N cycles in RD_MISS until `SRAM_ready`, then DONE. Stall is N+1 cycles.
- Store: same shape as a read miss; stall is N+1 cycles. `cache_invalidate` fires only in the request cycle.
- Back-to-back: a new request may be presented in the cycle after DONE.
- Reset (`rst`=0 sampled at an edge):
  - State goes to IDLE and latches clear to 0.
  - Next cycle: `SRAM_R_EN`=`SRAM_W_EN`=`cache_fill`=`cache_invalidate`=0, `read_data`=0.
  - `ready`=1 if there is no request.
  - An in-flight SRAM access is abandoned; a late `SRAM_ready` is ignored.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0], both reset to 0.
  - `hit_count` increments on each IDLE read hit. `miss_count` increments on each IDLE→RD_MISS transition.
  - Counters wrap modulo 2^32.
- Not defined: the ports and counter logic are absent; the rest of the behaviour is identical.

## Structure
- Shared package:
  - FSM state enum (IDLE, RD_MISS, WR, DONE).
  - `LINE_W`, `WORD_W`.
  - Offset-select bit index (2) and line-align mask width (3).
- Sub-module `cache_stats`: the two counters. Instantiated only under `CACHE_STATS_EN`.

## Test plan
- Read hit: `MEM_R_EN`=1, `cache_hit`=1, `cache_read_data`=0xDEADBEEF → same cycle `ready`=1, `read_data`=0xDEADBEEF, no `SRAM_R_EN`.
- Read miss:
  - Stimulus: `address`=0x0000040C, `cache_hit`=0, `SRAM_ready` after 5 cycles with `SRAM_read_data`=0x11112222_33334444.
  - `SRAM_address`=0x00000408 throughout RD_MISS.
  - `cache_fill` pulses once, exactly in the `SRAM_ready` cycle.
  - Next cycle `ready`=1, `read_data`=0x33334444. Total stall is 6 cycles.
- Store hit:
  - Stimulus: `MEM_W_EN`=1, `cache_hit`=1, `address`=0x410, `write_data`=0xCAFE0001.
  - `cache_invalidate`=1 for one cycle only.
  - `SRAM_W_EN`=1 with 0x410/0xCAFE0001 until `SRAM_ready`; `ready`=1 the following cycle.
- Simultaneous `MEM_R_EN`=`MEM_W_EN`=1 → WR path taken, `SRAM_R_EN` never asserted.
- Reset mid-miss: `rst`=0 during RD_MISS → next cycle IDLE, all strobes 0, `read_data`=0. A stray `SRAM_ready` afterwards causes no `cache_fill`.
- `CACHE_STATS_EN`: 3 hits + 2 misses → `hit_count`=3, `miss_count`=2. After reset, both are 0.
